pacman_motion: RTL and testbench
================================

PACMAN_MOTION -- requirements
Module: pacman_motion

Interface
REQ-001 Parameter STEP, default 1: pixels moved per frame tick; legal values are 1, 2, 4 and 8 only.
REQ-002 Parameter START_X, default 10'd32, and START_Y, default 10'd32: the reset position (tile 1,1).
REQ-003 Clk  in  1  sole clock.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 frame_tick  in  1  one-Clk-cycle pulse per video frame, already in the Clk domain.
REQ-006 keycode  in  8  USB HID keycode; 0x1A=W/up, 0x16=S/down, 0x04=A/left, 0x07=D/right, any other value = no request.
REQ-007 is_wall_up, is_wall_down, is_wall_left, is_wall_right  in  1 each  wall-block look-ahead flags, computed combinationally from Ball_X_Pos_out/Ball_Y_Pos_out.
REQ-008 Ball_X_Pos_out, Ball_Y_Pos_out  out  10 each  top-left pixel of the 32x32 sprite; fed back to the wall block.
REQ-009 dir  out  2  current heading (dir_t).
REQ-010 moving  out  1  1 while the sprite advances on ticks.
REQ-011 tile_x  out  5, tile_y  out  4  tile indices (position >> 5).
REQ-012 tile_entered  out  1  one-cycle pulse when a step lands on a tile-aligned position.

Function
REQ-013 Keycode decode SHALL run every cycle; a valid direction key loads pending_dir and sets pending_valid, while an invalid code leaves both unchanged.
REQ-014 All state SHALL update only on cycles where frame_tick=1; wall flags are sampled on that same cycle, and outputs change on the following edge (latency 1 cycle).
REQ-015 aligned = (X[4:0]==0 && Y[4:0]==0).
REQ-016 Reverse (pending_dir opposite dir) SHALL be taken on the next tick regardless of alignment.
REQ-017 A perpendicular pending_dir SHALL be taken only when aligned and the wall flag for pending_dir is 0; otherwise it stays pending.
REQ-018 When a turn is taken, dir SHALL become pending_dir, pending_valid SHALL clear, and the step SHALL use the new dir in the same tick.
REQ-019 A pending_dir equal to dir SHALL clear pending_valid and restart motion if the sprite is stopped.
REQ-020 FSM states:
- STOPPED: on a tick, if the wall flag for the resolved dir is 0, step and go to MOVING; otherwise stay.
- MOVING: on a tick, if the wall flag for dir is 1, hold position and go to STOPPED; otherwise step.
REQ-021 moving SHALL equal (state==MOVING).
REQ-022 Step arithmetic: up Y-=STEP, down Y+=STEP, left X-=STEP, right X+=STEP, using 10-bit unsigned math.
REQ-023 Results SHALL be clamped to X in [0,608] and Y in [0,448]; no wrap-around.
REQ-024 tile_entered SHALL pulse the cycle after a step whose result is aligned, and SHALL NOT pulse on hold or stop.

Reset
REQ-025 Reset SHALL produce: X=START_X, Y=START_Y, dir=RIGHT, state=STOPPED, pending_valid=0, tile_entered=0.
REQ-026 Reset SHALL take priority over frame_tick, and assertion mid-move SHALL return the sprite to start on the next edge.

Structure
REQ-027 Package pacman_pkg SHALL hold dir_t (UP=0, DOWN=1, LEFT=2, RIGHT=3), the four keycode constants, TILE=32, and the maze limits.
REQ-028 One sub-module, key_decoder (keycode to valid plus dir_t), SHALL be instantiated; the FSM and datapath SHALL stay in pacman_motion.

Verification (bench instantiates the real wall block in the loop)
REQ-029 Start and right: Reset, then key D, then 96 ticks -> X=128, Y=32, moving=1; next tick -> moving=0 and X stays 128.
REQ-030 Start and down: Reset, then key S, then 256 ticks -> Y=288; next tick -> moving=0 and tile_y=9.
REQ-031 Queued turn: moving right from (32,32), key S at X=40 -> no turn at X=64 or 96; at X=128, dir=DOWN and Y=33 on the next tick.
REQ-032 Reverse: moving right at X=50, key A -> the next tick gives X=49 and dir=LEFT.
REQ-033 Tile pulse and reset: tile_entered pulses exactly at X=64, 96 and 128; Reset asserted at X=70 -> (32,32), STOPPED, and no tick response during Reset.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite motion controller.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int TILE       = 32;
  localparam int TILE_SHIFT = $clog2(TILE);

  // Largest legal top-left coordinates for a 32x32 sprite on a 640x480 screen.
  localparam logic [9:0] X_MAX = 10'd608;
  localparam logic [9:0] Y_MAX = 10'd448;

  // Encodings pair up so that flipping bit 0 yields the opposite heading.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/pacman_motion_key_decoder.sv
// Maps a USB HID keycode onto a movement request (valid + heading).
module key_decoder
  import pacman_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       valid,
  output dir_t       key_dir
);

  always_comb begin
    valid   = 1'b1;
    key_dir = RIGHT;
    case (keycode)
      KEY_W:   key_dir = UP;
      KEY_S:   key_dir = DOWN;
      KEY_A:   key_dir = LEFT;
      KEY_D:   key_dir = RIGHT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_motion.sv
// Frame-ticked sprite motion: queued turns, wall stops, clamped stepping and tile-entry pulses.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int unsigned STEP    = 1,
  parameter logic [9:0]  START_X = 10'd32,
  parameter logic [9:0]  START_Y = 10'd32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       is_wall_up,
  input  logic       is_wall_down,
  input  logic       is_wall_left,
  input  logic       is_wall_right,
  output logic [9:0] Ball_X_Pos_out,
  output logic [9:0] Ball_Y_Pos_out,
  output dir_t       dir,
  output logic       moving,
  output logic [4:0] tile_x,
  output logic [3:0] tile_y,
  output logic       tile_entered
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("pacman_motion: STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [9:0]  STEP_10   = 10'(STEP);
  localparam logic [10:0] STEP_11   = 11'(STEP);
  localparam logic [9:0]  TILE_MASK = 10'(TILE - 1);

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  dir_t       dir_reg, dir_next;
  state_t     state_reg, state_next;
  dir_t       pending_dir_reg, pending_dir_next;
  logic       pending_valid_reg, pending_valid_next;
  logic       tile_entered_reg, tile_entered_next;

  logic       key_valid;
  dir_t       key_dir;

  key_decoder u_key_decoder (
    .keycode (keycode),
    .valid   (key_valid),
    .key_dir (key_dir)
  );

  function automatic logic wall_of(input dir_t d, input logic wu, input logic wd,
                                   input logic wl, input logic wr);
    case (d)
      UP:      return wu;
      DOWN:    return wd;
      LEFT:    return wl;
      default: return wr;
    endcase
  endfunction

  logic       aligned;
  logic       pend_reverse, pend_same, pend_perp;
  logic       turn_take;
  dir_t       res_dir;
  logic       blocked;
  logic [9:0] x_step, y_step;
  logic       step_aligned;

  assign aligned = ((x_reg & TILE_MASK) == 10'd0) && ((y_reg & TILE_MASK) == 10'd0);

  // A reverse never needs alignment; a perpendicular turn waits for a tile corner and an open path.
  always_comb begin
    pend_reverse = pending_valid_reg && (pending_dir_reg == opposite(dir_reg));
    pend_same    = pending_valid_reg && (pending_dir_reg == dir_reg);
    pend_perp    = pending_valid_reg && !pend_reverse && !pend_same;
    turn_take    = pend_reverse ||
                   (pend_perp && aligned &&
                    !wall_of(pending_dir_reg, is_wall_up, is_wall_down, is_wall_left, is_wall_right));
    res_dir      = turn_take ? pending_dir_reg : dir_reg;
    blocked      = wall_of(res_dir, is_wall_up, is_wall_down, is_wall_left, is_wall_right);
  end

  always_comb begin
    x_step = x_reg;
    y_step = y_reg;
    case (res_dir)
      UP:    y_step = (y_reg < STEP_10) ? 10'd0 : (y_reg - STEP_10);
      DOWN:  y_step = (({1'b0, y_reg} + STEP_11) > {1'b0, Y_MAX}) ? Y_MAX
                                                                   : 10'({1'b0, y_reg} + STEP_11);
      LEFT:  x_step = (x_reg < STEP_10) ? 10'd0 : (x_reg - STEP_10);
      RIGHT: x_step = (({1'b0, x_reg} + STEP_11) > {1'b0, X_MAX}) ? X_MAX
                                                                   : 10'({1'b0, x_reg} + STEP_11);
      default: ;
    endcase
    step_aligned = ((x_step & TILE_MASK) == 10'd0) && ((y_step & TILE_MASK) == 10'd0);
  end

  always_comb begin
    x_next             = x_reg;
    y_next             = y_reg;
    dir_next           = dir_reg;
    state_next         = state_reg;
    pending_dir_next   = pending_dir_reg;
    pending_valid_next = pending_valid_reg;
    tile_entered_next  = 1'b0;

    if (frame_tick) begin
      dir_next = res_dir;
      if (pend_reverse || pend_same || turn_take) begin
        pending_valid_next = 1'b0;
      end
      case (state_reg)
        STOPPED: begin
          if (!blocked) begin
            state_next        = MOVING;
            x_next            = x_step;
            y_next            = y_step;
            tile_entered_next = step_aligned;
          end
        end
        MOVING: begin
          if (blocked) begin
            state_next = STOPPED;
          end else begin
            x_next            = x_step;
            y_next            = y_step;
            tile_entered_next = step_aligned;
          end
        end
        default: state_next = STOPPED;
      endcase
    end

    // A fresh key on the same cycle as a taken turn becomes the new request.
    if (key_valid) begin
      pending_valid_next = 1'b1;
      pending_dir_next   = key_dir;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_reg             <= START_X;
      y_reg             <= START_Y;
      dir_reg           <= RIGHT;
      state_reg         <= STOPPED;
      pending_dir_reg   <= RIGHT;
      pending_valid_reg <= 1'b0;
      tile_entered_reg  <= 1'b0;
    end else begin
      x_reg             <= x_next;
      y_reg             <= y_next;
      dir_reg           <= dir_next;
      state_reg         <= state_next;
      pending_dir_reg   <= pending_dir_next;
      pending_valid_reg <= pending_valid_next;
      tile_entered_reg  <= tile_entered_next;
    end
  end

  assign Ball_X_Pos_out = x_reg;
  assign Ball_Y_Pos_out = y_reg;
  assign dir            = dir_reg;
  assign moving         = (state_reg == MOVING);
  assign tile_x         = 5'(x_reg >> TILE_SHIFT);
  assign tile_y         = 4'(y_reg >> TILE_SHIFT);
  assign tile_entered   = tile_entered_reg;

endmodule

// File: tb/tb_pacman_motion.sv
// Scoreboarded bench: a small maze model drives the wall flags from the sprite position.
module tb_pacman_motion;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       is_wall_up, is_wall_down, is_wall_left, is_wall_right;
  logic [9:0] Ball_X_Pos_out, Ball_Y_Pos_out;
  dir_t       dir;
  logic       moving;
  logic [4:0] tile_x;
  logic [3:0] tile_y;
  logic       tile_entered;

  pacman_motion dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .keycode        (keycode),
    .is_wall_up     (is_wall_up),
    .is_wall_down   (is_wall_down),
    .is_wall_left   (is_wall_left),
    .is_wall_right  (is_wall_right),
    .Ball_X_Pos_out (Ball_X_Pos_out),
    .Ball_Y_Pos_out (Ball_Y_Pos_out),
    .dir            (dir),
    .moving         (moving),
    .tile_x         (tile_x),
    .tile_y         (tile_y),
    .tile_entered   (tile_entered)
  );

  always #5 Clk = ~Clk;

  // Open corridors: row 1 cols 1..4, col 1 rows 1..9, col 4 rows 1..5; all else is wall.
  function automatic logic cell_open(input int c, input int r);
    return (r == 1 && c >= 1 && c <= 4) || (c == 1 && r >= 1 && r <= 9) ||
           (c == 4 && r >= 1 && r <= 5);
  endfunction

  int bx, by;
  always_comb begin
    bx = int'(Ball_X_Pos_out);
    by = int'(Ball_Y_Pos_out);
    is_wall_right = (bx % 32 == 0) &&
                    (!cell_open(bx / 32 + 1, by / 32) || !cell_open(bx / 32 + 1, (by + 31) / 32));
    is_wall_left  = (bx % 32 == 0) &&
                    (!cell_open(bx / 32 - 1, by / 32) || !cell_open(bx / 32 - 1, (by + 31) / 32));
    is_wall_down  = (by % 32 == 0) &&
                    (!cell_open(bx / 32, by / 32 + 1) || !cell_open((bx + 31) / 32, by / 32 + 1));
    is_wall_up    = (by % 32 == 0) &&
                    (!cell_open(bx / 32, by / 32 - 1) || !cell_open((bx + 31) / 32, by / 32 - 1));
  end

  localparam logic [5:0] MX = 6'd1, MY = 6'd2, MD = 6'd4, MM = 6'd8, MT = 6'd16, MTY = 6'd32;

  typedef struct {
    int         idx;
    string      nm;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] d;
    logic       mv;
    logic       te;
    logic [3:0] ty;
    logic [5:0] msk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   n_ticks = 0;
  int   resp_idx = 0;
  logic tick_seen = 1'b0;

  task automatic expect_at(input int off, input string nm, input logic [9:0] x, input logic [9:0] y,
                           input dir_t d, input logic mv, input logic te, input logic [3:0] ty,
                           input logic [5:0] msk);
    exp_t e;
    e.idx = n_ticks + off; e.nm = nm; e.x = x; e.y = y; e.d = 2'(d);
    e.mv = mv; e.te = te; e.ty = ty; e.msk = msk;
    sb.push_back(e);
  endtask

  task automatic compare_entry(input exp_t e);
    logic ok;
    ok = 1'b1;
    if (e.msk[0] && Ball_X_Pos_out != e.x) ok = 1'b0;
    if (e.msk[1] && Ball_Y_Pos_out != e.y) ok = 1'b0;
    if (e.msk[2] && 2'(dir) != e.d) ok = 1'b0;
    if (e.msk[3] && moving != e.mv) ok = 1'b0;
    if (e.msk[4] && tile_entered != e.te) ok = 1'b0;
    if (e.msk[5] && tile_y != e.ty) ok = 1'b0;
    checks++;
    if (ok) begin
      passes++;
      $display("ok   %s tick=%0d x=%0d y=%0d dir=%0d moving=%0b te=%0b", e.nm, e.idx,
               Ball_X_Pos_out, Ball_Y_Pos_out, dir, moving, tile_entered);
    end else begin
      $display("FAIL %s tick=%0d got x=%0d y=%0d dir=%0d moving=%0b te=%0b ty=%0d, want x=%0d y=%0d dir=%0d moving=%0b te=%0b ty=%0d mask=%b",
               e.nm, e.idx, Ball_X_Pos_out, Ball_Y_Pos_out, dir, moving, tile_entered, tile_y,
               e.x, e.y, e.d, e.mv, e.te, e.ty, e.msk);
    end
  endtask

  task automatic check_now(input string nm, input int got, input int want);
    checks++;
    if (got == want) begin
      passes++;
      $display("ok   %s = %0d", nm, got);
    end else begin
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: each accepted tick yields one response on the following edge.
  always @(posedge Clk) tick_seen <= frame_tick && !Reset;

  always @(negedge Clk) begin
    if (tick_seen) begin
      resp_idx++;
      while (sb.size() > 0 && sb[0].idx == resp_idx) begin
        compare_entry(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00;
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk); keycode = k;
    @(negedge Clk); keycode = 8'h00;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      @(negedge Clk); frame_tick = 1'b1; n_ticks++;
      @(negedge Clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check_now("rst_x", int'(Ball_X_Pos_out), 32);
    check_now("rst_y", int'(Ball_Y_Pos_out), 32);
    check_now("rst_dir", int'(dir), int'(RIGHT));
    check_now("rst_moving", int'(moving), 0);
    check_now("rst_te", int'(tile_entered), 0);
    check_now("rst_tile_x", int'(tile_x), 1);
    Reset = 1'b0;

    // Right along row 1 until the wall past tile 4; tile pulses at 64, 96, 128.
    do_reset();
    press(KEY_D);
    for (int k = 1; k <= 96; k++) begin
      expect_at(k, (k == 96) ? "right_end" : "right_te", 10'(32 + k), 10'd32, RIGHT, 1'b1,
                ((32 + k) % 32 == 0), 4'd1, (k == 96) ? (MX | MY | MM | MT) : (MX | MT));
    end
    expect_at(97, "right_stop", 10'd128, 10'd32, RIGHT, 1'b0, 1'b0, 4'd1, MX | MM | MT);
    run_ticks(97);

    // Down column 1 until the wall below tile row 9.
    do_reset();
    press(KEY_S);
    expect_at(1, "down_first", 10'd32, 10'd33, DOWN, 1'b1, 1'b0, 4'd1, MX | MY | MD | MM);
    expect_at(256, "down_end", 10'd32, 10'd288, DOWN, 1'b1, 1'b1, 4'd9, MY | MM | MT | MTY);
    expect_at(257, "down_stop", 10'd32, 10'd288, DOWN, 1'b0, 1'b0, 4'd9, MY | MM | MT | MTY);
    run_ticks(257);

    // Queued down turn waits through blocked corners at 64 and 96, taken at 128.
    do_reset();
    press(KEY_D);
    expect_at(8, "q_x40", 10'd40, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MY | MD);
    run_ticks(8);
    press(KEY_S);
    press(8'h55);
    expect_at(24, "q_x64", 10'd64, 10'd32, RIGHT, 1'b1, 1'b1, 4'd1, MX | MY | MD | MT);
    expect_at(25, "q_x65", 10'd65, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MY | MD);
    expect_at(56, "q_x96", 10'd96, 10'd32, RIGHT, 1'b1, 1'b1, 4'd1, MX | MY | MD | MT);
    expect_at(57, "q_x97", 10'd97, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MY | MD);
    expect_at(88, "q_x128", 10'd128, 10'd32, RIGHT, 1'b1, 1'b1, 4'd1, MX | MY | MD);
    expect_at(89, "q_turn", 10'd128, 10'd33, DOWN, 1'b1, 1'b0, 4'd1, MX | MY | MD | MM);
    run_ticks(89);

    // Reverse mid-tile.
    do_reset();
    press(KEY_D);
    expect_at(18, "rev_x50", 10'd50, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MD);
    run_ticks(18);
    press(KEY_A);
    expect_at(1, "rev_x49", 10'd49, 10'd32, LEFT, 1'b1, 1'b0, 4'd1, MX | MY | MD | MM);
    run_ticks(1);

    // Reset mid-move with a tick pending on the same cycle.
    do_reset();
    press(KEY_D);
    expect_at(38, "pre_rst_x70", 10'd70, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MM);
    run_ticks(38);
    @(negedge Clk); Reset = 1'b1; frame_tick = 1'b1;
    @(negedge Clk); Reset = 1'b0; frame_tick = 1'b0;
    check_now("mid_rst_x", int'(Ball_X_Pos_out), 32);
    check_now("mid_rst_y", int'(Ball_Y_Pos_out), 32);
    check_now("mid_rst_moving", int'(moving), 0);
    check_now("mid_rst_te", int'(tile_entered), 0);
    check_now("mid_rst_dir", int'(dir), int'(RIGHT));
    expect_at(1, "post_rst_step", 10'd33, 10'd32, RIGHT, 1'b1, 1'b0, 4'd1, MX | MY | MM | MT);
    run_ticks(1);

    repeat (4) @(negedge Clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL sb_leftover %s tick=%0d never observed (responses seen %0d)", e.nm, e.idx, resp_idx);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
